// File: rtl/cbus_rr_arbiter.sv
// Round-robin arbiter sharing one cbus master port between NUM_REQ requesters.
// A grant is held for a whole transaction and released on the response last beat.
module cbus_rr_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic [NUM_REQ-1:0]                ireq_valid,
    input  logic [NUM_REQ-1:0]                ireq_is_write,
    input  logic [3*NUM_REQ-1:0]              ireq_size,
    input  logic [ADDR_WIDTH*NUM_REQ-1:0]     ireq_addr,
    input  logic [(DATA_WIDTH/8)*NUM_REQ-1:0] ireq_strobe,
    input  logic [DATA_WIDTH*NUM_REQ-1:0]     ireq_data,
    input  logic [4*NUM_REQ-1:0]              ireq_len,
    output logic [NUM_REQ-1:0]                iresp_ready,
    output logic [NUM_REQ-1:0]                iresp_last,
    output logic [DATA_WIDTH-1:0]             iresp_data,
    output logic                              oreq_valid,
    output logic                              oreq_is_write,
    output logic [2:0]                        oreq_size,
    output logic [ADDR_WIDTH-1:0]             oreq_addr,
    output logic [DATA_WIDTH/8-1:0]           oreq_strobe,
    output logic [DATA_WIDTH-1:0]             oreq_data,
    output logic [3:0]                        oreq_len,
    input  logic                              oresp_ready,
    input  logic                              oresp_last,
    input  logic [DATA_WIDTH-1:0]             oresp_data,
    output logic                              busy,
    output logic [NUM_REQ-1:0]                grant
);

    localparam int SW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int STRB_W = DATA_WIDTH / 8;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [SW-1:0]   ptr;
    logic [SW-1:0]   ptr_nx;
    logic [SW-1:0]   sel;
    logic [SW-1:0]   sel_nx;
    logic [SW-1:0]   winner;
    logic [SW-1:0]   idx;
    int              idx_i;
    logic            any_valid;
    logic [NUM_REQ-1:0] sel_oh;

    // Round-robin scan starting at ptr; the closest valid requester wins.
    always_comb begin
        winner    = ptr;
        any_valid = 1'b0;
        idx_i     = 0;
        idx       = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx_i = int'(ptr) + i;
            if (idx_i >= NUM_REQ) idx_i = idx_i - NUM_REQ;
            idx = SW'(idx_i);
            if (ireq_valid[idx]) begin
                winner    = idx;
                any_valid = 1'b1;
            end
        end
    end

    // Next state: arbitrate in IDLE, release on the last response beat.
    always_comb begin
        state_nx = state;
        sel_nx   = sel;
        ptr_nx   = ptr;
        unique case (state)
            IDLE: begin
                if (any_valid) begin
                    sel_nx   = winner;
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                if (oresp_ready && oresp_last) begin
                    state_nx = IDLE;
                    if (sel == SW'(NUM_REQ - 1)) ptr_nx = '0;
                    else                         ptr_nx = sel + SW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, pointer and selection registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            ptr   <= '0;
            sel   <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
            sel   <= sel_nx;
        end
    end

    // Request field mux from the selected requester.
    always_comb begin
        oreq_is_write = ireq_is_write[0];
        oreq_size     = ireq_size[2:0];
        oreq_addr     = ireq_addr[ADDR_WIDTH-1:0];
        oreq_strobe   = ireq_strobe[STRB_W-1:0];
        oreq_data     = ireq_data[DATA_WIDTH-1:0];
        oreq_len      = ireq_len[3:0];
        for (int k = 0; k < NUM_REQ; k++) begin
            if (sel == SW'(k)) begin
                oreq_is_write = ireq_is_write[k];
                oreq_size     = ireq_size[3*k +: 3];
                oreq_addr     = ireq_addr[ADDR_WIDTH*k +: ADDR_WIDTH];
                oreq_strobe   = ireq_strobe[STRB_W*k +: STRB_W];
                oreq_data     = ireq_data[DATA_WIDTH*k +: DATA_WIDTH];
                oreq_len      = ireq_len[4*k +: 4];
            end
        end
    end

    // Grant, valid and response steering; only the granted requester sees beats.
    always_comb begin
        sel_oh      = NUM_REQ'(1) << sel;
        busy        = (state == BUSY);
        grant       = busy ? sel_oh : '0;
        oreq_valid  = busy & ireq_valid[sel];
        iresp_ready = grant & {NUM_REQ{oresp_ready}};
        iresp_last  = grant & {NUM_REQ{oresp_last}};
        iresp_data  = oresp_data;
    end

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Scoreboard bench for cbus_rr_arbiter: stimulus queues expected grants and
// response beats, a negedge monitor pops and compares them as they appear.
module tb_cbus_rr_arbiter;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic [1:0]   ireq_valid = '0;
    logic [1:0]   ireq_is_write = '0;
    logic [5:0]   ireq_size = '0;
    logic [63:0]  ireq_addr = '0;
    logic [7:0]   ireq_strobe = '0;
    logic [63:0]  ireq_data = '0;
    logic [7:0]   ireq_len = '0;
    logic [1:0]   iresp_ready;
    logic [1:0]   iresp_last;
    logic [31:0]  iresp_data;
    logic         oreq_valid;
    logic         oreq_is_write;
    logic [2:0]   oreq_size;
    logic [31:0]  oreq_addr;
    logic [3:0]   oreq_strobe;
    logic [31:0]  oreq_data;
    logic [3:0]   oreq_len;
    logic         oresp_ready = 1'b0;
    logic         oresp_last = 1'b0;
    logic [31:0]  oresp_data = '0;
    logic         busy;
    logic [1:0]   grant;

    cbus_rr_arbiter #(
        .NUM_REQ(2),
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .ireq_valid(ireq_valid),
        .ireq_is_write(ireq_is_write),
        .ireq_size(ireq_size),
        .ireq_addr(ireq_addr),
        .ireq_strobe(ireq_strobe),
        .ireq_data(ireq_data),
        .ireq_len(ireq_len),
        .iresp_ready(iresp_ready),
        .iresp_last(iresp_last),
        .iresp_data(iresp_data),
        .oreq_valid(oreq_valid),
        .oreq_is_write(oreq_is_write),
        .oreq_size(oreq_size),
        .oreq_addr(oreq_addr),
        .oreq_strobe(oreq_strobe),
        .oreq_data(oreq_data),
        .oreq_len(oreq_len),
        .oresp_ready(oresp_ready),
        .oresp_last(oresp_last),
        .oresp_data(oresp_data),
        .busy(busy),
        .grant(grant)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  g;
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  strb;
        logic [31:0] data;
        logic [3:0]  len;
        int          cyc;
    } gexp_t;

    typedef struct {
        logic [1:0]  g;
        logic [1:0]  rdy;
        logic [1:0]  lst;
        logic [31:0] data;
        int          cyc;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];
    gexp_t ge;
    rexp_t re;

    int   cyc = 0;
    logic rst_seen = 1'b0;
    logic busy_prev = 1'b0;
    logic last_prev = 1'b0;
    logic done = 1'b0;
    logic final_done = 1'b0;
    int   vectors = 0;
    int   errors = 0;
    logic [1:0] exp_rdy;
    logic [1:0] exp_lst;

    // cycle counter and reset sampling at the active edge
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= !resetn;
    end

    // monitor: invariants plus scoreboard pops, sampled on the falling edge
    always @(negedge clk) begin
        if (rst_seen) begin
            vectors++;
            if (busy !== 1'b0 || grant !== 2'b00 || oreq_valid !== 1'b0 ||
                iresp_ready !== 2'b00 || iresp_last !== 2'b00) begin
                errors++;
                $display("FAIL reset_state cyc=%0d busy=%b grant=%b oreq_valid=%b iresp_ready=%b expected all 0",
                         cyc, busy, grant, oreq_valid, iresp_ready);
            end
        end else begin
            exp_rdy = busy ? (grant & {2{oresp_ready}}) : 2'b00;
            exp_lst = busy ? (grant & {2{oresp_last}}) : 2'b00;
            vectors++;
            if ((busy && !$onehot(grant)) || (!busy && grant !== 2'b00) ||
                (!busy && oreq_valid !== 1'b0) || iresp_ready !== exp_rdy ||
                iresp_last !== exp_lst || iresp_data !== oresp_data) begin
                errors++;
                $display("FAIL invariant cyc=%0d busy=%b grant=%b iresp_ready=%b/%b iresp_last=%b/%b oreq_valid=%b",
                         cyc, busy, grant, iresp_ready, exp_rdy, iresp_last, exp_lst, oreq_valid);
            end
            if (last_prev) begin
                vectors++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL release_bubble cyc=%0d busy=%b required 0", cyc, busy);
                end
            end
            if (busy && !busy_prev) begin
                vectors++;
                if (gq.size() == 0) begin
                    errors++;
                    $display("FAIL grant_unexpected cyc=%0d grant=%b", cyc, grant);
                end else begin
                    ge = gq.pop_front();
                    if (grant !== ge.g || cyc != ge.cyc || oreq_valid !== 1'b1 ||
                        oreq_addr !== ge.addr || oreq_is_write !== ge.wr ||
                        oreq_strobe !== ge.strb || oreq_data !== ge.data ||
                        oreq_len !== ge.len) begin
                        errors++;
                        $display("FAIL grant_start got cyc=%0d g=%b a=%h w=%b s=%h d=%h l=%0d v=%b want cyc=%0d g=%b a=%h w=%b s=%h d=%h l=%0d v=1",
                                 cyc, grant, oreq_addr, oreq_is_write, oreq_strobe, oreq_data, oreq_len, oreq_valid,
                                 ge.cyc, ge.g, ge.addr, ge.wr, ge.strb, ge.data, ge.len);
                    end
                end
            end
            if (iresp_ready !== 2'b00) begin
                vectors++;
                if (rq.size() == 0) begin
                    errors++;
                    $display("FAIL resp_unexpected cyc=%0d iresp_ready=%b", cyc, iresp_ready);
                end else begin
                    re = rq.pop_front();
                    if (iresp_ready !== re.rdy || iresp_last !== re.lst ||
                        iresp_data !== re.data || grant !== re.g || cyc != re.cyc) begin
                        errors++;
                        $display("FAIL resp_beat got cyc=%0d rdy=%b last=%b d=%h g=%b want cyc=%0d rdy=%b last=%b d=%h g=%b",
                                 cyc, iresp_ready, iresp_last, iresp_data, grant,
                                 re.cyc, re.rdy, re.lst, re.data, re.g);
                    end
                end
            end
        end
        if (done && !final_done) begin
            vectors++;
            if (gq.size() != 0 || rq.size() != 0) begin
                errors++;
                $display("FAIL drain pending grants=%0d beats=%0d required 0", gq.size(), rq.size());
            end
            final_done <= 1'b1;
        end
        busy_prev <= busy;
        last_prev <= (iresp_last !== 2'b00);
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_req(input int k, input logic vld, input logic w,
                           input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] d, input logic [3:0] l);
        ireq_valid[k]          = vld;
        ireq_is_write[k]       = w;
        ireq_size[3*k +: 3]    = 3'd2;
        ireq_addr[32*k +: 32]  = a;
        ireq_strobe[4*k +: 4]  = s;
        ireq_data[32*k +: 32]  = d;
        ireq_len[4*k +: 4]     = l;
    endtask

    task automatic push_g(input logic [1:0] g, input logic [31:0] a,
                          input logic w, input logic [3:0] s,
                          input logic [31:0] d, input logic [3:0] l,
                          input int c);
        gexp_t e;
        e.g = g; e.addr = a; e.wr = w; e.strb = s;
        e.data = d; e.len = l; e.cyc = c;
        gq.push_back(e);
    endtask

    task automatic respond(input logic [1:0] g, input logic lst,
                           input logic [31:0] d);
        rexp_t e;
        e.g = g; e.rdy = g; e.lst = lst ? g : 2'b00;
        e.data = d; e.cyc = cyc;
        rq.push_back(e);
        oresp_ready = 1'b1;
        oresp_last  = lst;
        oresp_data  = d;
        tick(1);
        oresp_ready = 1'b0;
        oresp_last  = 1'b0;
    endtask

    initial begin
        // reset held 3 cycles with every requester valid
        resetn = 1'b0;
        set_req(0, 1, 0, 32'h0000_0100, 4'h0, 32'h0, 4'd0);
        set_req(1, 1, 0, 32'h0000_0200, 4'h0, 32'h0, 4'd0);
        tick(3);
        resetn = 1'b1;
        set_req(1, 0, 0, 32'h0000_0200, 4'h0, 32'h0, 4'd0);
        push_g(2'b01, 32'h0000_0100, 0, 4'h0, 32'h0, 4'd0, cyc + 1);
        tick(1);
        respond(2'b01, 1, 32'hA5A5_0001);
        set_req(0, 0, 0, 32'h0000_0100, 4'h0, 32'h0, 4'd0);
        tick(1);

        // single read from requester 1, answered on the 3rd busy cycle
        set_req(1, 1, 0, 32'h1FC0_0000, 4'h0, 32'h0, 4'd0);
        push_g(2'b10, 32'h1FC0_0000, 0, 4'h0, 32'h0, 4'd0, cyc + 1);
        tick(3);
        respond(2'b10, 1, 32'hDEAD_BEEF);
        set_req(1, 0, 0, 32'h1FC0_0000, 4'h0, 32'h0, 4'd0);

        // 4-beat burst on requester 0 while requester 1 waits
        set_req(0, 1, 0, 32'h0000_1000, 4'h0, 32'h0, 4'd3);
        set_req(1, 1, 0, 32'h0000_2000, 4'h0, 32'h0, 4'd0);
        push_g(2'b01, 32'h0000_1000, 0, 4'h0, 32'h0, 4'd3, cyc + 1);
        push_g(2'b10, 32'h0000_2000, 0, 4'h0, 32'h0, 4'd0, cyc + 6);
        tick(1);
        for (int b = 0; b < 4; b++)
            respond(2'b01, (b == 3), 32'hB000_0000 + b);
        set_req(0, 0, 0, 32'h0000_1000, 4'h0, 32'h0, 4'd3);
        tick(1);
        respond(2'b10, 1, 32'hC0DE_0002);
        set_req(1, 0, 0, 32'h0000_2000, 4'h0, 32'h0, 4'd0);

        // both requesters continuously valid, single beats alternate
        set_req(0, 1, 0, 32'h0000_0A00, 4'h0, 32'h0, 4'd0);
        set_req(1, 1, 0, 32'h0000_0B00, 4'h0, 32'h0, 4'd0);
        push_g(2'b01, 32'h0000_0A00, 0, 4'h0, 32'h0, 4'd0, cyc + 1);
        push_g(2'b10, 32'h0000_0B00, 0, 4'h0, 32'h0, 4'd0, cyc + 3);
        push_g(2'b01, 32'h0000_0A00, 0, 4'h0, 32'h0, 4'd0, cyc + 5);
        push_g(2'b10, 32'h0000_0B00, 0, 4'h0, 32'h0, 4'd0, cyc + 7);
        for (int t = 0; t < 4; t++) begin
            tick(1);
            respond((t % 2 == 0) ? 2'b01 : 2'b10, 1, 32'hD000_0000 + t);
        end
        set_req(0, 0, 0, 32'h0000_0A00, 4'h0, 32'h0, 4'd0);
        set_req(1, 0, 0, 32'h0000_0B00, 4'h0, 32'h0, 4'd0);

        // stray response handshake while idle must not reach any requester
        oresp_ready = 1'b1;
        oresp_last  = 1'b1;
        tick(2);
        oresp_ready = 1'b0;
        oresp_last  = 1'b0;

        // write fields forwarded from requester 1
        set_req(1, 1, 1, 32'h0000_3000, 4'hF, 32'h1234_5678, 4'd0);
        push_g(2'b10, 32'h0000_3000, 1, 4'hF, 32'h1234_5678, 4'd0, cyc + 1);
        tick(2);
        respond(2'b10, 1, 32'h0000_0000);
        set_req(1, 0, 0, 32'h0000_3000, 4'h0, 32'h0, 4'd0);

        // move ptr to 1, then reset in the middle of requester 1's burst
        set_req(0, 1, 0, 32'h0000_4000, 4'h0, 32'h0, 4'd0);
        push_g(2'b01, 32'h0000_4000, 0, 4'h0, 32'h0, 4'd0, cyc + 1);
        tick(1);
        respond(2'b01, 1, 32'hE000_0001);
        set_req(0, 1, 0, 32'h0000_5000, 4'h0, 32'h0, 4'd0);
        set_req(1, 1, 0, 32'h0000_6000, 4'h0, 32'h0, 4'd3);
        push_g(2'b10, 32'h0000_6000, 0, 4'h0, 32'h0, 4'd3, cyc + 1);
        tick(1);
        respond(2'b10, 0, 32'hE000_0002);
        respond(2'b10, 0, 32'hE000_0003);
        resetn = 1'b0;
        tick(1);
        resetn = 1'b1;
        push_g(2'b01, 32'h0000_5000, 0, 4'h0, 32'h0, 4'd0, cyc + 1);
        tick(1);
        respond(2'b01, 1, 32'hE000_0004);
        set_req(0, 0, 0, 32'h0000_5000, 4'h0, 32'h0, 4'd0);
        set_req(1, 0, 0, 32'h0000_6000, 4'h0, 32'h0, 4'd3);
        tick(3);

        done = 1'b1;
        tick(3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/cbus_rr_arbiter.md
Name: cbus_rr_arbiter

Overview:
- Shares one cached-bus (cbus) master port between NUM_REQ requesters, e.g. the instruction fetch and data memory ports of the core, ahead of the CBus-to-AXI converter.
- Uses round-robin grant. A grant is held for a whole transaction, burst included, and released on the beat where the response carries last.
- Response ready/last go only to the granted requester.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data beat width; strobe width is DATA_WIDTH/8.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- ireq_valid  in  NUM_REQ  per-requester request valid.
- ireq_is_write  in  NUM_REQ  per-requester write flag.
- ireq_size  in  3*NUM_REQ  per-requester beat size; slice k = bits [3k+2:3k].
- ireq_addr  in  ADDR_WIDTH*NUM_REQ  per-requester address.
- ireq_strobe  in  (DATA_WIDTH/8)*NUM_REQ  per-requester write strobe.
- ireq_data  in  DATA_WIDTH*NUM_REQ  per-requester write data.
- ireq_len  in  4*NUM_REQ  per-requester burst length code (beats minus 1).
- iresp_ready  out  NUM_REQ  per-requester beat accepted/returned.
- iresp_last  out  NUM_REQ  per-requester final beat.
- iresp_data  out  DATA_WIDTH  read data, broadcast to all requesters.
- oreq_valid, oreq_is_write, oreq_size, oreq_addr, oreq_strobe, oreq_data, oreq_len  out  1/1/3/ADDR_WIDTH/DATA_WIDTH/8/DATA_WIDTH/4  shared request.
- oresp_ready, oresp_last  in  1/1  shared response handshake.
- oresp_data  in  DATA_WIDTH  shared response data.
- busy  out  1  a grant is active.
- grant  out  NUM_REQ  one-hot current grant; 0 when idle.

Behaviour:
- Clock and reset: single clock clk; resetn is synchronous and active-low. All state updates on the rising clk edge.
- Reset values: state=IDLE, ptr=0, sel=0.
  - Outputs: busy=0, grant=0, oreq_valid=0, iresp_ready=0, iresp_last=0.
  - All other oreq_* fields are don't-care but driven from requester 0.
- State IDLE:
  - The winner is the first k with ireq_valid[k]=1, scanning ptr, ptr+1, ... mod NUM_REQ.
  - If any requester is valid: sel<=winner, state<=BUSY. The grant is registered, so oreq_valid rises the cycle after ireq_valid is first seen (1-cycle arbitration latency).
  - If none is valid: stay in IDLE.
- State BUSY:
  - oreq_* fields are a combinational mux of requester sel.
  - oreq_valid = ireq_valid[sel].
  - iresp_ready[sel]=oresp_ready and iresp_last[sel]=oresp_last; these are 0 for every other requester.
  - busy=1; grant=onehot(sel).
- Release:
  - On a cycle with oresp_ready=1 and oresp_last=1: state<=IDLE and ptr<=(sel+1) mod NUM_REQ.
  - The next grant is decided in the following IDLE cycle, giving exactly one bubble cycle between transactions.
- Bursts: non-last beats (oresp_ready=1, oresp_last=0) never release the grant, and the arbiter does not count beats. Termination is defined solely by oresp_last.
- Fairness: a requester that becomes valid waits at most NUM_REQ-1 other transactions.
- Requester protocol:
  - The granted requester holds valid and all fields stable until its last beat.
  - If it drops ireq_valid mid-grant, oreq_valid drops with it, but the grant is kept (no re-arbitration).
  - This is a protocol violation; it is not flagged.
- Non-granted requesters:
  - A requester whose valid rises during another's grant sees no iresp activity.
  - It stays pending until its turn.
- Simultaneous events: last-beat release and new requests in the same cycle are handled as above. Release wins; arbitration happens in the next cycle using the updated ptr.
- Reset mid-transaction: returns to reset state next edge; the in-flight transaction is abandoned. Downstream is reset by the same resetn.
- oresp_ready while IDLE: ignored, with no effect on iresp_ready.

Test Plan:
- Reset: hold resetn=0 for 3 cycles with all ireq_valid=1 -> busy=0, grant=0, oreq_valid=0 throughout. First grant goes to requester 0 one cycle after resetn=1.
- Single read: req1 valid, addr=0x1FC0_0000, len=0. Respond ready+last at the 3rd BUSY cycle with data 0xDEADBEEF -> oreq_addr=0x1FC0_0000, iresp_ready[1]=iresp_last[1]=1 on that cycle only, iresp_ready[0]=0, and busy=0 on the next cycle.
- Burst hold: req0 is a len=3 read and req1 is also valid. Respond 4 beats with last on the 4th -> grant stays 0b01 for all 4 beats, then 1 idle cycle, then grant=0b10.
- Round-robin: both requesters continuously valid with single-beat transactions -> grant sequence 01,10,01,10. No requester is granted twice in a row.
- Write forwarding: req1 write, strobe=0xF, data=0x12345678 -> oreq_is_write=1, oreq_strobe=0xF, oreq_data=0x12345678 while granted.
- Reset mid-burst: assert resetn=0 after beat 2 of a len=3 burst -> busy=0 and oreq_valid=0 on the next edge, ptr=0, and grant restarts from requester 0.
